// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared parking-lot constants, response codes and entry FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int c_PARK_SLOTS = 16;

    localparam logic [1:0] RESP_PARKED   = 2'b00;
    localparam logic [1:0] RESP_OCCUPIED = 2'b01;
    localparam logic [1:0] RESP_INVALID  = 2'b10;
    localparam logic [1:0] RESP_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_GATE  = 2'd2,
        ST_RESP  = 2'd3
    } entry_state_t;

endpackage
`default_nettype wire

// File: rtl/gate_timer.sv
`default_nettype none
// ============================================================================
// Module      : gate_timer
// Description : Gate-open wait counter; expire flags the last allowed cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_timer #(
    parameter int GATE_TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int c_TW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_LAST = c_TW'(GATE_TIMEOUT - 1);

    logic [c_TW-1:0] r_count;

    // Saturates at the last cycle so a stalled owner never sees a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en && !expire) begin
            r_count <= r_count + c_TW'(1);
        end
    end

    assign expire = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/slot_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : slot_entry_ctrl
// Description : Entry gate controller owning the lot occupancy map and count.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_entry_ctrl
    import parking_pkg::*;
#(
    parameter int N_SLOTS      = c_PARK_SLOTS,
    parameter int FLAT_W       = 5,
    parameter int GATE_TIMEOUT = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [FLAT_W-1:0]            req_flat,
    input  logic                         exit_valid,
    input  logic [FLAT_W-1:0]            exit_flat,
    input  logic                         car_passed,
    output logic                         gate_open,
    output logic                         resp_valid,
    output logic [1:0]                   resp_code,
    output logic [FLAT_W-1:0]            resp_flat,
    output logic [N_SLOTS-1:0]           occ_map,
    output logic [$clog2(N_SLOTS+1)-1:0] occ_count,
    output logic                         lot_full
);

    localparam int                 c_CNT_W      = $clog2(N_SLOTS + 1);
    localparam logic [N_SLOTS-1:0] c_ONE        = N_SLOTS'(1);
    localparam logic [FLAT_W-1:0]  c_FLAT_LIMIT = FLAT_W'(N_SLOTS);

    entry_state_t         r_state;
    logic [FLAT_W-1:0]    r_flat;
    logic                 r_gate_open;
    logic                 r_resp_valid;
    logic [1:0]           r_resp_code;
    logic [FLAT_W-1:0]    r_resp_flat;
    logic [N_SLOTS-1:0]   r_occ_map;
    logic [c_CNT_W-1:0]   r_occ_count;

    logic [N_SLOTS-1:0]   w_flat_mask;
    logic [N_SLOTS-1:0]   w_exit_mask;
    logic                 w_flat_valid;
    logic                 w_flat_busy;
    logic                 w_exit_hit;
    logic                 w_set;
    logic                 w_timeout_clr;
    logic                 w_expire;

    // Out-of-range flats shift the one-hot mask out entirely.
    assign w_flat_mask  = c_ONE << r_flat;
    assign w_exit_mask  = c_ONE << exit_flat;
    assign w_flat_valid = (r_flat < c_FLAT_LIMIT);
    assign w_flat_busy  = |(r_occ_map & w_flat_mask);

    // The reserved slot cannot be vacated while its car is still at the gate.
    assign w_exit_hit    = exit_valid && (exit_flat < c_FLAT_LIMIT)
                           && (|(r_occ_map & w_exit_mask))
                           && !((r_state == ST_GATE) && (exit_flat == r_flat));
    assign w_set         = (r_state == ST_CHECK) && w_flat_valid && !w_flat_busy;
    assign w_timeout_clr = (r_state == ST_GATE) && !car_passed && w_expire;

    gate_timer #(
        .GATE_TIMEOUT (GATE_TIMEOUT)
    ) u_gate_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (r_state == ST_CHECK),
        .count_en ((r_state == ST_GATE) && !car_passed),
        .expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_flat       <= '0;
            r_gate_open  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_code  <= RESP_PARKED;
            r_resp_flat  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_flat  <= req_flat;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!w_flat_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= RESP_INVALID;
                        r_resp_flat  <= r_flat;
                        r_state      <= ST_RESP;
                    end else if (w_flat_busy) begin
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= RESP_OCCUPIED;
                        r_resp_flat  <= r_flat;
                        r_state      <= ST_RESP;
                    end else begin
                        r_gate_open  <= 1'b1;
                        r_state      <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (car_passed) begin
                        r_gate_open  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= RESP_PARKED;
                        r_resp_flat  <= r_flat;
                        r_state      <= ST_RESP;
                    end else if (w_expire) begin
                        r_gate_open  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_code  <= RESP_TIMEOUT;
                        r_resp_flat  <= r_flat;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Set and clears never target the same bit, so the count moves by exact deltas.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ_map   <= '0;
            r_occ_count <= '0;
        end else begin
            r_occ_map   <= (r_occ_map | (w_set ? w_flat_mask : '0))
                           & ~(w_exit_hit    ? w_exit_mask : '0)
                           & ~(w_timeout_clr ? w_flat_mask : '0);
            r_occ_count <= r_occ_count + c_CNT_W'(w_set)
                           - c_CNT_W'(w_exit_hit) - c_CNT_W'(w_timeout_clr);
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign gate_open  = r_gate_open;
    assign resp_valid = r_resp_valid;
    assign resp_code  = r_resp_code;
    assign resp_flat  = r_resp_flat;
    assign occ_map    = r_occ_map;
    assign occ_count  = r_occ_count;
    assign lot_full   = (r_occ_count == c_CNT_W'(N_SLOTS));

endmodule
`default_nettype wire

// File: tb/tb_slot_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_slot_entry_ctrl
// Description : Randomized and directed self-checking bench for slot_entry_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slot_entry_ctrl;

    localparam int NS = 16;
    localparam int FW = 5;
    localparam int TO = 8;

    localparam int P_IDLE   = 0;
    localparam int P_DECIDE = 1;
    localparam int P_GATE   = 2;
    localparam int P_RESP   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [FW-1:0] req_flat = '0;
    logic          exit_valid = 1'b0;
    logic [FW-1:0] exit_flat = '0;
    logic          car_passed = 1'b0;
    logic          req_ready;
    logic          gate_open;
    logic          resp_valid;
    logic [1:0]    resp_code;
    logic [FW-1:0] resp_flat;
    logic [NS-1:0] occ_map;
    logic [4:0]    occ_count;
    logic          lot_full;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    slot_entry_ctrl #(
        .N_SLOTS      (NS),
        .FLAT_W       (FW),
        .GATE_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_flat   (req_flat),
        .exit_valid (exit_valid),
        .exit_flat  (exit_flat),
        .car_passed (car_passed),
        .gate_open  (gate_open),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .resp_flat  (resp_flat),
        .occ_map    (occ_map),
        .occ_count  (occ_count),
        .lot_full   (lot_full)
    );

    // Reference: which slots are taken, plus where the current visitor is in its transaction.
    bit            m_occ [NS];
    int            m_phase;
    int            m_gate_cycles;
    logic [FW-1:0] m_flat;
    bit            e_gate;
    bit            e_resp;
    logic [1:0]    e_code;
    logic [FW-1:0] e_rflat;

    function automatic int m_count();
        int s = 0;
        for (int k = 0; k < NS; k++) s += m_occ[k];
        return s;
    endfunction

    function automatic logic [NS-1:0] m_map();
        logic [NS-1:0] m = '0;
        for (int k = 0; k < NS; k++) m[k] = m_occ[k];
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) m_occ[k] = 1'b0;
        m_phase = P_IDLE; m_gate_cycles = 0; m_flat = '0;
        e_gate = 1'b0; e_resp = 1'b0; e_code = 2'b00; e_rflat = '0;
    endtask

    task automatic respond(input logic [1:0] code);
        e_resp = 1'b1; e_code = code; e_rflat = m_flat; e_gate = 1'b0; m_phase = P_RESP;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                bit nxt [NS];
                nxt = m_occ;
                e_resp = 1'b0;
                if (exit_valid && int'(exit_flat) < NS && m_occ[int'(exit_flat)]
                    && !(m_phase == P_GATE && exit_flat == m_flat))
                    nxt[int'(exit_flat)] = 1'b0;
                case (m_phase)
                    P_IDLE: if (req_valid) begin m_flat = req_flat; m_phase = P_DECIDE; end
                    P_DECIDE: begin
                        if (int'(m_flat) >= NS) respond(2'b10);
                        else if (m_occ[int'(m_flat)]) respond(2'b01);
                        else begin
                            nxt[int'(m_flat)] = 1'b1;
                            e_gate = 1'b1; m_gate_cycles = 0; m_phase = P_GATE;
                        end
                    end
                    P_GATE: begin
                        m_gate_cycles++;
                        if (car_passed) respond(2'b00);
                        else if (m_gate_cycles == TO) begin
                            nxt[int'(m_flat)] = 1'b0;
                            respond(2'b11);
                        end
                    end
                    default: m_phase = P_IDLE;
                endcase
                m_occ = nxt;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("gate_open",  gate_open,  e_gate);
            check("resp_valid", resp_valid, e_resp);
            check("resp_code",  resp_code,  e_code);
            check("resp_flat",  resp_flat,  e_rflat);
            check("occ_map",    occ_map,    m_map());
            check("occ_count",  occ_count,  m_count());
            check("lot_full",   lot_full,   m_count() == NS);
            check("req_ready",  req_ready,  m_phase == P_IDLE);
        end
    end

    task automatic run_req(input logic [FW-1:0] flat, input int car_at,
                           output logic [1:0] code, output logic [FW-1:0] rflat,
                           output int gcycles, output int lat);
        int n = 0;
        gcycles = 0; lat = 0; code = 'x; rflat = 'x;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_flat = flat;
        @(negedge clk);
        req_valid = 1'b0; lat = 1; n = 0;
        while (!resp_valid && n < 100) begin
            if (gate_open) begin
                gcycles++;
                if (car_at != 0 && gcycles == car_at) car_passed = 1'b1;
            end
            @(negedge clk);
            lat++; n++;
        end
        car_passed = 1'b0;
        check("resp_arrived", resp_valid, 1'b1);
        code = resp_code; rflat = resp_flat;
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]    code;
        logic [FW-1:0] rflat;
        int            gc, lat, n;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_gate", gate_open, 1'b0);
        check("rst_occ_map", occ_map, 16'h0000);
        check("rst_resp", {resp_valid, resp_code, resp_flat}, 8'h00);

        run_req(5'd3, 5, code, rflat, gc, lat);
        check("park3_code", code, 2'b00);
        check("park3_flat", rflat, 5'd3);
        check("park3_gate_cycles", gc, 5);
        check("park3_map", occ_map, 16'h0008);
        check("park3_count", occ_count, 5'd1);

        run_req(5'd3, 0, code, rflat, gc, lat);
        check("dup3_code", code, 2'b01);
        check("dup3_latency", lat, 2);
        check("dup3_gate_cycles", gc, 0);
        check("dup3_count", occ_count, 5'd1);

        run_req(5'd20, 0, code, rflat, gc, lat);
        check("inv20_code", code, 2'b10);
        check("inv20_flat", rflat, 5'd20);
        check("inv20_map", occ_map, 16'h0008);

        run_req(5'd5, 0, code, rflat, gc, lat);
        check("to5_code", code, 2'b11);
        check("to5_gate_cycles", gc, TO);
        check("to5_map", occ_map, 16'h0008);
        check("to5_count", occ_count, 5'd1);

        for (int f = 0; f < NS; f++) begin
            run_req(FW'(f), 1, code, rflat, gc, lat);
            check("fill_code", code, (f == 3) ? 2'b01 : 2'b00);
        end
        @(negedge clk);
        check("full_flag", lot_full, 1'b1);
        check("full_map", occ_map, 16'hFFFF);
        exit_valid = 1'b1; exit_flat = 5'd7;
        @(negedge clk);
        exit_valid = 1'b0;
        check("exit7_count", occ_count, 5'd15);
        check("exit7_full", lot_full, 1'b0);
        run_req(5'd7, 2, code, rflat, gc, lat);
        check("reenter7_code", code, 2'b00);
        check("reenter7_full", lot_full, 1'b1);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            req_valid  = ($urandom_range(0, 2) == 0);
            req_flat   = FW'($urandom_range(0, 19));
            exit_valid = ($urandom_range(0, 3) == 0);
            exit_flat  = FW'($urandom_range(0, 17));
            car_passed = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        req_valid = 1'b0; exit_valid = 1'b0; car_passed = 1'b0;

        do_reset();
        @(negedge clk);
        req_valid = 1'b1; req_flat = 5'd9;
        @(negedge clk);
        req_valid = 1'b0; n = 0;
        while (!gate_open && n < 10) begin @(negedge clk); n++; end
        check("mid_gate_open", gate_open, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gate", gate_open, 1'b0);
        check("arst_map", occ_map, 16'h0000);
        check("arst_count", occ_count, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready", req_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slot_entry_ctrl.md
Name: slot_entry_ctrl

Overview:
- Entry-side counterpart of the slot-exit logic. Accepts a vehicle-entry request tagged with a flat number and checks that flat's dedicated slot.
- On a free slot: reserves it, opens the gate and waits for the car-passed sensor. On timeout the reservation is released.
- Owns the live occupancy bitmap and occupancy count. Also applies exit clears from the exit side so both ends share one consistent view of the lot.

Parameters:
- N_SLOTS, 16, number of slots; one per flat; valid flats 0..N_SLOTS-1
- FLAT_W, 5, flat-number width; must satisfy 2**FLAT_W > N_SLOTS so out-of-range flats are encodable
- GATE_TIMEOUT, 1000, cycles gate_open stays high waiting for car_passed

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assertion, active-low
- req_valid  in  1  entry request present
- req_ready  out  1  high only in IDLE; request accepted on req_valid&req_ready
- req_flat  in  FLAT_W  flat number of entering vehicle
- exit_valid  in  1  one-cycle exit-clear strobe from exit side
- exit_flat  in  FLAT_W  flat whose slot is vacated
- car_passed  in  1  gate sensor, synchronous, level sampled each edge
- gate_open  out  1  gate drive
- resp_valid  out  1  one-cycle response pulse
- resp_code  out  2  00 parked, 01 already occupied, 10 invalid flat, 11 timeout
- resp_flat  out  FLAT_W  flat the response refers to
- occ_map  out  N_SLOTS  bit k = slot k occupied or reserved
- occ_count  out  $clog2(N_SLOTS+1)  number of set bits in occ_map
- lot_full  out  1  occ_count == N_SLOTS, combinational from count

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; occ_map=0, occ_count=0, gate_open=0, resp_valid=0, resp_code=00, resp_flat=0, timer=0; req_ready=1.
  - Mid-operation reset drops gate_open immediately and discards any reservation.
- FSM IDLE -> CHECK -> {RESP | GATE} ; GATE -> RESP ; RESP -> IDLE.
- IDLE: on accept at edge T, latch req_flat; next state CHECK.
- CHECK (cycle T+1), evaluated on registered occ_map:
  - flat >= N_SLOTS -> code 10, go RESP.
  - bit set -> code 01, go RESP.
  - else set bit, occ_count+1, clear timer, go GATE.
- GATE:
  - gate_open=1 for every GATE cycle (first GATE cycle T+2).
  - car_passed=1 sampled at an edge -> code 00, go RESP.
  - Otherwise timer increments. When timer==GATE_TIMEOUT-1 with no car_passed: clear reserved bit, occ_count-1, code 11, go RESP.
  - car_passed and timeout on the same edge -> car_passed wins (code 00).
- RESP: resp_valid=1 for exactly one cycle with resp_code/resp_flat, then IDLE. Reject latency is accept edge + 2 cycles.
- Exit clears, any state:
  - exit_valid with exit_flat < N_SLOTS and bit set clears the bit and decrements occ_count.
  - Out-of-range or already-clear exits are ignored; the exit side reports them.
  - Exit for the flat currently reserved in GATE is ignored, since the car is not yet inside.
- Simultaneous set (CHECK) and clear of a different slot: both apply; occ_count net unchanged.
- Exit of the same flat during CHECK: CHECK sees the pre-clear map, so the result is code 01; the clear still applies.
- occ_count never wraps: increment only on a set of a clear bit, decrement only on a clear of a set bit.
- Requests are not queued: req_ready=0 outside IDLE.

Decomposition:
- Shared package parking_pkg:
  - N_SLOTS default tied to the team's parking-slot count constant.
  - Response code constants RESP_PARKED / RESP_OCCUPIED / RESP_INVALID / RESP_TIMEOUT.
  - FSM state enum.
- One sub-module, gate_timer: counter with start/clear inputs and expire output, parameterised by GATE_TIMEOUT.

Test Plan:
- Reset, then req flat 3 with car_passed 5 cycles into GATE -> gate_open high 5 cycles, resp_code 00, resp_flat 3, occ_map=0x0008, occ_count=1.
- Repeat req flat 3 -> resp_valid two cycles after accept, code 01, gate_open never asserted, occ_count stays 1.
- Req flat 20 (N_SLOTS=16) -> code 10, occ_map unchanged.
- GATE_TIMEOUT=8, req flat 5, car_passed held 0 -> gate_open high exactly 8 cycles, code 11, bit 5 clear, occ_count back to prior value.
- Park flats 0..15 -> lot_full=1. exit_flat 7 strobe -> lot_full=0, occ_count=15. Re-entry of flat 7 -> code 00.
- Assert rst_n=0 mid-GATE for flat 9 -> gate_open drops without waiting for clk, occ_map=0. After release, req_ready=1.
